// File: rtl/op_sequencer.sv
// Sequencer for the EX_12 block: latches a/b on start, then steps sel 00..11 with a DWELL-cycle hold per code.
// Optional SEQ_LOOP_EN adds a loop input that restarts the pass with fresh operands instead of finishing.
module op_sequencer #(
    parameter int WIDTH = 4,
    parameter int DWELL = 3,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQ_LOOP_EN
    input  logic             loop,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [1:0]       sel,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    // A dwell of zero would never advance, so it is clamped to one cycle.
    localparam int          DW   = (DWELL < 1) ? 1 : DWELL;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] a_d, b_d;
    logic [1:0]       sel_d;
    logic             valid_d, busy_d, done_d;
    logic             wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            sel   <= 2'b00;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            a     <= a_d;
            b     <= b_d;
            sel   <= sel_d;
            valid <= valid_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a_d     = a;
        b_d     = b;
        sel_d   = sel;
        valid_d = valid;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef SEQ_LOOP_EN
        wrap    = loop;
`else
        wrap    = 1'b0;
`endif

        case (state)
            IDLE: begin
                sel_d   = 2'b00;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt != LAST) begin
                    cnt_d = cnt + 1'b1;
                end else if (sel != 2'b11) begin
                    sel_d = sel + 2'b01;
                    cnt_d = '0;
                end else if (wrap) begin
                    // Loop restart re-samples the operands and keeps the handshake live.
                    sel_d = 2'b00;
                    cnt_d = '0;
                    a_d   = a_in;
                    b_d   = b_in;
                end else begin
                    state_d = FIN;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sel_d   = 2'b00;
                    cnt_d   = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: two instances (DWELL=3 and DWELL=1) checked against a step-index model.
// Loop-mode checks are compiled only when SEQ_LOOP_EN is defined.
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start3 = 1'b0;
    logic       start1 = 1'b0;
    logic       loop_v = 1'b0;
    logic [3:0] a_in = 4'h0;
    logic [3:0] b_in = 4'h0;

    logic [3:0] a3, b3, a1, b1;
    logic [1:0] sel3, sel1;
    logic       valid3, busy3, done3, valid1, busy1, done1;

    int tests = 0;
    int failed = 0;

    // Model: t = -1 idle, 0..4D-1 live step index, 4D the done cycle.
    int         t[2];
    int         dw[2];
    logic [3:0] ea[2];
    logic [3:0] eb[2];

    always #5 clk = ~clk;

    op_sequencer #(.WIDTH(4), .DWELL(3), .CW(8)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
`ifdef SEQ_LOOP_EN
        .loop(loop_v),
`endif
        .a_in(a_in), .b_in(b_in), .a(a3), .b(b3), .sel(sel3),
        .valid(valid3), .busy(busy3), .done(done3)
    );

    op_sequencer #(.WIDTH(4), .DWELL(1), .CW(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
`ifdef SEQ_LOOP_EN
        .loop(loop_v),
`endif
        .a_in(a_in), .b_in(b_in), .a(a1), .b(b1), .sel(sel1),
        .valid(valid1), .busy(busy1), .done(done1)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            t[i]  = -1;
            ea[i] = 4'h0;
            eb[i] = 4'h0;
        end
    endtask

    task automatic modelStep(input int i, input logic st, input logic lp);
        int last;
        last = 4 * dw[i] - 1;
        if (t[i] < 0) begin
            if (st) begin
                t[i]  = 0;
                ea[i] = a_in;
                eb[i] = b_in;
            end
        end else if (t[i] < last) begin
            t[i]++;
        end else if (t[i] == last) begin
            if (lp) begin
                t[i]  = 0;
                ea[i] = a_in;
                eb[i] = b_in;
            end else begin
                t[i] = last + 1;
            end
        end else begin
            t[i] = -1;
        end
    endtask

    task automatic checkAll(input string phase);
        logic [1:0] es;
        logic       live, fin;
        for (int i = 0; i < 2; i++) begin
            live = (t[i] >= 0) && (t[i] < 4 * dw[i]);
            fin  = (t[i] == 4 * dw[i]);
            es   = live ? 2'(t[i] / dw[i]) : 2'b00;
            if (i == 0) begin
                checkOutput({phase, " d3.a"},     {4'h0, a3},     {4'h0, ea[0]});
                checkOutput({phase, " d3.b"},     {4'h0, b3},     {4'h0, eb[0]});
                checkOutput({phase, " d3.sel"},   {6'h0, sel3},   {6'h0, es});
                checkOutput({phase, " d3.valid"}, {7'h0, valid3}, {7'h0, live});
                checkOutput({phase, " d3.busy"},  {7'h0, busy3},  {7'h0, live});
                checkOutput({phase, " d3.done"},  {7'h0, done3},  {7'h0, fin});
            end else begin
                checkOutput({phase, " d1.a"},     {4'h0, a1},     {4'h0, ea[1]});
                checkOutput({phase, " d1.b"},     {4'h0, b1},     {4'h0, eb[1]});
                checkOutput({phase, " d1.sel"},   {6'h0, sel1},   {6'h0, es});
                checkOutput({phase, " d1.valid"}, {7'h0, valid1}, {7'h0, live});
                checkOutput({phase, " d1.busy"},  {7'h0, busy1},  {7'h0, live});
                checkOutput({phase, " d1.done"},  {7'h0, done1},  {7'h0, fin});
            end
        end
    endtask

    // One clock: model advances on the edge with the inputs it saw, outputs are checked 1 time unit later.
    task automatic applyStimulus(input string phase);
        logic lp;
`ifdef SEQ_LOOP_EN
        lp = loop_v;
`else
        lp = 1'b0;
`endif
        @(posedge clk);
        if (reset) begin
            modelStep(0, start3, lp);
            modelStep(1, start1, lp);
        end
        #1;
        checkAll(phase);
    endtask

    initial begin
        dw[0] = 3;
        dw[1] = 1;
        modelReset();

        // Reset held with live-looking inputs.
        a_in   = 4'h5;
        b_in   = 4'h3;
        start3 = 1'b1;
        #2;
        checkAll("reset");
        applyStimulus("reset_hold");
        reset = 1'b1;
        applyStimulus("first_edge");
        start3 = 1'b0;

        // Basic pass with operand isolation and ignored start pulses.
        for (int k = 0; k < 14; k++) begin
            if (k == 4) a_in = 4'hA;
            start3 = (k == 5 || k == 9);
            applyStimulus("basic");
        end
        start3 = 1'b0;
        applyStimulus("idle");

        // Abort while sel=10.
        a_in   = 4'h9;
        b_in   = 4'h6;
        start3 = 1'b1;
        applyStimulus("abort_start");
        start3 = 1'b0;
        for (int k = 0; k < 20 && t[0] != 6; k++) applyStimulus("abort_run");
        checkOutput("abort_at_sel10", {6'h0, sel3}, 8'h02);
        #3;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("abort_async");
        #1;
        reset = 1'b1;
        for (int k = 0; k < 12; k++) applyStimulus("post_abort");

        // DWELL=1 instance with start held high across consecutive passes.
        a_in   = 4'hC;
        b_in   = 4'h2;
        start1 = 1'b1;
        for (int k = 0; k < 15; k++) applyStimulus("dwell1_held");
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus("dwell1_tail");

`ifdef SEQ_LOOP_EN
        // Loop wrap with new operands, then a normal finish.
        a_in   = 4'h5;
        b_in   = 4'h3;
        loop_v = 1'b1;
        start3 = 1'b1;
        applyStimulus("loop_start");
        start3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (t[0] == 9) a_in = 4'h7;
            applyStimulus("loop_pass");
        end
        checkOutput("loop_wrap_a", {4'h0, a3}, 8'h07);
        loop_v = 1'b0;
        for (int k = 0; k < 14; k++) applyStimulus("loop_exit");
`endif

        // Randomised traffic on both instances.
        for (int k = 0; k < 300; k++) begin
            a_in   = 4'($urandom);
            b_in   = 4'($urandom);
            start3 = ($urandom_range(0, 7) == 0);
            start1 = ($urandom_range(0, 3) == 0);
`ifdef SEQ_LOOP_EN
            loop_v = ($urandom_range(0, 3) == 0);
`endif
            applyStimulus("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Upstream stage feeding the EX_12 operation block.
- Latches a pair of 4-bit operands on a start request.
- Drives a, b and sel so that sel steps 00→01→10→11, holding each code for a programmable number of clock cycles.
- Replaces hand-timed sel stimulus with a deterministic, handshaked sequence; reports busy/done to the controller above it.

Parameters:
- WIDTH, 4, operand width of a_in/b_in/a/b.
- DWELL, 3, clock cycles each sel code is held (legal 1..255; 0 is treated as 1).
- CW, 8, width of internal dwell counter (must hold DWELL-1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a sequence; sampled only in IDLE.
- a_in  input  WIDTH  operand A source.
- b_in  input  WIDTH  operand B source.
- a  output  WIDTH  registered operand A to EX_12.
- b  output  WIDTH  registered operand B to EX_12.
- sel  output  2  registered operation select to EX_12.
- valid  output  1  high while a/b/sel carry a live sequence step.
- busy  output  1  high from first step cycle through last step cycle.
- done  output  1  one-cycle pulse after final step.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (reset=0, asynchronous): state=IDLE; a=0, b=0, sel=00, valid=0, busy=0, done=0, cnt=0. Reset mid-sequence aborts immediately with no done pulse.
- Reset release: first rising edge with reset=1 evaluates IDLE normally.
- States: IDLE, RUN, FIN.
- IDLE, start=0: stay in IDLE; a/b hold their last values; sel=00, valid=0, busy=0, done=0.
- IDLE, start=1 at edge N: on the same edge a←a_in, b←b_in, sel←00, cnt←0, valid←1, busy←1, state←RUN. Latency 1 edge: outputs are live after edge N.
- RUN, cnt<DWELL-1: cnt←cnt+1; sel/a/b hold.
- RUN, cnt==DWELL-1 and sel<11: sel←sel+1, cnt←0.
- RUN, cnt==DWELL-1 and sel==11: state←FIN, valid←0, busy←0, done←1, sel←00, cnt←0.
- FIN: done←0, state←IDLE (done high exactly one cycle).
- Each sel code is valid for exactly DWELL cycles; total valid/busy time is 4×DWELL cycles.
- start is ignored in RUN and FIN; no queuing. start held high continuously re-triggers on the cycle after FIN (IDLE sees start=1).
- a_in/b_in changes during RUN do not affect a/b.
- DWELL=1: sel changes every cycle; busy lasts 4 cycles.
- sel never wraps inside a pass; 11→00 occurs only on entry to FIN (or on loop wrap, see below).

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: adds input port loop (1 bit).
  - At the end of the sel=11 step, if loop=1: sel←00, cnt←0, a←a_in, b←b_in, stay in RUN (valid/busy remain 1, no done).
  - If loop=0: enter FIN as normal.
  - loop is sampled only on that terminal cycle.
- Undefined: loop port absent; sequence is always a single pass.

Test Plan:
- Reset: reset=0 with a_in=5, b_in=3, start=1 → a=0, b=0, sel=00, valid=0, busy=0, done=0. Release reset → start taken on first edge.
- Basic pass (DWELL=3): a_in=4'h5, b_in=4'h3, start pulse at edge N → after N: a=5, b=3. sel=00 for 3 cycles, then 01, 10, 11 (3 cycles each); valid/busy high for 12 cycles; done=1 for one cycle; then IDLE with sel=00.
- Operand isolation: change a_in to 4'hA mid-RUN → a stays 5 for the whole pass. start pulses during RUN produce no restart.
- Abort: assert reset=0 while sel=10 → outputs clear asynchronously (before the next edge); no done pulse.
- Edge DWELL=1 with start held high: sel steps 00,01,10,11 on consecutive cycles; done pulse; the next pass starts the cycle after FIN.
- SEQ_LOOP_EN defined, loop=1, a_in changed to 4'h7 during the sel=11 step: sel wraps 11→00 with a=7, no done pulse. loop=0 on the next terminal cycle → done pulse, then IDLE.
